// File: rtl/ctrl_pipe_multi.sv
// Multi-lane MIPS control unit: decodes LANES opcodes per cycle and carries
// the control bundles through the ID/EX, EX/MEM and MEM/WB stage registers.
// Also provides stall/flush bubble insertion, illegal-opcode flagging and a
// saturating count of retired instructions.
module ctrl_pipe_multi #(
   parameter int LANES = 2,
   parameter int OPW   = 6,
   parameter int CNTW  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [LANES-1:0]      in_valid,
   input  logic [LANES*OPW-1:0]  op_code,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  in_ready,
   output logic [LANES-1:0]      ex_valid,
   output logic [LANES-1:0]      ex_reg_dst,
   output logic [LANES-1:0]      ex_alu_src,
   output logic [LANES-1:0]      ex_illegal,
   output logic [2*LANES-1:0]    ex_alu_op,
   output logic [LANES-1:0]      ex_beq,
   output logic [LANES-1:0]      ex_bne,
   output logic [LANES-1:0]      ex_bgtz,
   output logic [LANES-1:0]      mem_valid,
   output logic [LANES-1:0]      mem_read,
   output logic [LANES-1:0]      mem_write,
   output logic [LANES-1:0]      mem_beq,
   output logic [LANES-1:0]      mem_bne,
   output logic [LANES-1:0]      mem_bgtz,
   output logic [LANES-1:0]      wb_valid,
   output logic [LANES-1:0]      wb_reg_write,
   output logic [LANES-1:0]      wb_mem_to_reg,
   output logic [CNTW-1:0]       retire_cnt
);

   localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
   localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
   localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
   localparam logic [OPW-1:0] OP_BGTZ  = OPW'(6'b000111);

   // popcount of up to 4 lanes, plus headroom so the sum never overflows
   localparam int PW = $clog2(LANES + 1);
   localparam int SW = CNTW + 3;

   // Full control bundle held in ID/EX
   typedef struct packed {
      logic       valid;
      logic       illegal;
      logic       reg_dst;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       beq;
      logic       bne;
      logic       bgtz;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
   } ctrl_t;

   // Subset still needed once the EX stage has consumed its controls
   typedef struct packed {
      logic valid;
      logic beq;
      logic bne;
      logic bgtz;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_t;

   // Subset still needed in write-back
   typedef struct packed {
      logic valid;
      logic reg_write;
      logic mem_to_reg;
   } wb_t;

   function automatic ctrl_t decode(input logic v, input logic [OPW-1:0] op);
      ctrl_t c;
      c = '0;
      if (v) begin
         c.valid = 1'b1;
         case (op)
            OP_RTYPE: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = 2'b10; end
            OP_ADDI:  begin c.alu_src = 1'b1; c.reg_write = 1'b1; end
            OP_LW:    begin
               c.alu_src = 1'b1; c.mem_to_reg = 1'b1;
               c.reg_write = 1'b1; c.mem_read = 1'b1;
            end
            OP_SW:    begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
            OP_BEQ:   begin c.alu_op = 2'b01; c.beq = 1'b1; end
            OP_BNE:   begin c.alu_op = 2'b01; c.bne = 1'b1; end
            OP_BGTZ:  begin c.alu_op = 2'b01; c.bgtz = 1'b1; end
            // unknown opcode travels as a valid no-op so it still retires
            default:  c.illegal = 1'b1;
         endcase
      end
      return c;
   endfunction

   ctrl_t dec [LANES];
   ctrl_t id_ex_reg [LANES];
   mem_t  ex_mem_reg [LANES];
   wb_t   mem_wb_reg [LANES];

   logic [CNTW-1:0] retire_cnt_reg;
   logic [CNTW-1:0] retire_cnt_next;
   logic [PW-1:0]   retire_pop;
   logic [SW-1:0]   retire_sum;

   assign in_ready   = !stall;
   assign retire_cnt = retire_cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign dec[gi] = decode(in_valid[gi], op_code[gi*OPW +: OPW]);

         assign ex_valid[gi]          = id_ex_reg[gi].valid;
         assign ex_reg_dst[gi]        = id_ex_reg[gi].reg_dst;
         assign ex_alu_src[gi]        = id_ex_reg[gi].alu_src;
         assign ex_illegal[gi]        = id_ex_reg[gi].illegal;
         assign ex_alu_op[2*gi +: 2]  = id_ex_reg[gi].alu_op;
         assign ex_beq[gi]            = id_ex_reg[gi].beq;
         assign ex_bne[gi]            = id_ex_reg[gi].bne;
         assign ex_bgtz[gi]           = id_ex_reg[gi].bgtz;

         assign mem_valid[gi]         = ex_mem_reg[gi].valid;
         assign mem_read[gi]          = ex_mem_reg[gi].mem_read;
         assign mem_write[gi]         = ex_mem_reg[gi].mem_write;
         assign mem_beq[gi]           = ex_mem_reg[gi].beq;
         assign mem_bne[gi]           = ex_mem_reg[gi].bne;
         assign mem_bgtz[gi]          = ex_mem_reg[gi].bgtz;

         assign wb_valid[gi]          = mem_wb_reg[gi].valid;
         assign wb_reg_write[gi]      = mem_wb_reg[gi].reg_write;
         assign wb_mem_to_reg[gi]     = mem_wb_reg[gi].mem_to_reg;
      end
   endgenerate

   // Count lanes in WB and form the saturated next retire count
   always_comb begin
      retire_pop = '0;
      for (int l = 0; l < LANES; l++) begin
         retire_pop = retire_pop + PW'(mem_wb_reg[l].valid);
      end
      retire_sum = SW'(retire_cnt_reg) + SW'(retire_pop);
      if (retire_sum > SW'({CNTW{1'b1}})) begin
         retire_cnt_next = {CNTW{1'b1}};
      end else begin
         retire_cnt_next = retire_sum[CNTW-1:0];
      end
   end

   // Stage registers: only the ID/EX load sees stall/flush; later stages always advance
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int l = 0; l < LANES; l++) begin
            id_ex_reg[l]  <= '0;
            ex_mem_reg[l] <= '0;
            mem_wb_reg[l] <= '0;
         end
         retire_cnt_reg <= '0;
      end else begin
         for (int l = 0; l < LANES; l++) begin
            id_ex_reg[l] <= (stall || flush) ? '0 : dec[l];

            ex_mem_reg[l].valid      <= id_ex_reg[l].valid;
            ex_mem_reg[l].beq        <= id_ex_reg[l].beq;
            ex_mem_reg[l].bne        <= id_ex_reg[l].bne;
            ex_mem_reg[l].bgtz       <= id_ex_reg[l].bgtz;
            ex_mem_reg[l].mem_read   <= id_ex_reg[l].mem_read;
            ex_mem_reg[l].mem_write  <= id_ex_reg[l].mem_write;
            ex_mem_reg[l].reg_write  <= id_ex_reg[l].reg_write;
            ex_mem_reg[l].mem_to_reg <= id_ex_reg[l].mem_to_reg;

            mem_wb_reg[l].valid      <= ex_mem_reg[l].valid;
            mem_wb_reg[l].reg_write  <= ex_mem_reg[l].reg_write;
            mem_wb_reg[l].mem_to_reg <= ex_mem_reg[l].mem_to_reg;
         end
         retire_cnt_reg <= retire_cnt_next;
      end
   end

endmodule
